// File: rtl/frame_buf_rd_ctrl_if.sv
// Read-port and output-stream bundle for frame_buf_rd_ctrl.
// The master modport is the controller side; the slave modport is the memory/sink side.
interface frame_buf_rd_ctrl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 3
);
    logic                  mem_rd_rdy;
    logic                  mem_rd_en_l;
    logic [ADDR_WIDTH-1:0] mem_rd_addr;
    logic [DATA_WIDTH-1:0] mem_rd_data;
    logic                  mem_rd_data_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;

    modport master (
        input  mem_rd_rdy, mem_rd_data, mem_rd_data_valid, out_ready,
        output mem_rd_en_l, mem_rd_addr, out_data, out_valid
    );

    modport slave (
        output mem_rd_rdy, mem_rd_data, mem_rd_data_valid, out_ready,
        input  mem_rd_en_l, mem_rd_addr, out_data, out_valid
    );
endinterface

// File: rtl/frame_buf_rd_ctrl.sv
// Frame buffer read controller: issues credit-limited reads behind the writer pointer and
// streams words from a small prefetch FIFO. Optional macro UNDERRUN_CNT_EN adds underrun_cnt.
module frame_buf_rd_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 3,
    parameter int START_ADDR = 2,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   wr_ptr,
    frame_buf_rd_ctrl_if.master   bus,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  protocol_err
`ifdef UNDERRUN_CNT_EN
    ,
    output logic [15:0]           underrun_cnt
`endif
);

    localparam int IDX_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_REQ   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
    localparam logic [ADDR_WIDTH:0]   START_PTR = {1'b0, ADDR_WIDTH'(START_ADDR)};

    logic [1:0]            state;
    logic [ADDR_WIDTH:0]   rd_ptr;
    logic [CNT_W-1:0]      fifo_count;
    logic [CNT_W-1:0]      outstanding;
    logic [IDX_W-1:0]      wr_idx;
    logic [IDX_W-1:0]      rd_idx;
    logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];

    logic avail;
    logic credit;
    logic issue;
    logic push;
    logic pop;
    logic out_valid_i;

    // Words in the FIFO plus reads in flight never exceed FIFO_DEPTH, so a return always fits.
    assign avail  = (rd_ptr != wr_ptr);
    assign credit = ({1'b0, fifo_count} + {1'b0, outstanding}) < (CNT_W + 1)'(FIFO_DEPTH);
    assign issue  = (state == ST_REQ) && avail && credit && bus.mem_rd_rdy;
    assign push   = bus.mem_rd_data_valid && (outstanding != '0);

    assign out_valid_i     = (fifo_count != '0);
    assign pop             = out_valid_i && bus.out_ready;
    assign bus.out_valid   = out_valid_i;
    assign bus.out_data    = out_valid_i ? fifo_mem[rd_idx] : '0;
    assign bus.mem_rd_en_l = !((state == ST_REQ) && avail && credit);
    assign bus.mem_rd_addr = rd_ptr[ADDR_WIDTH-1:0];

    // NOTE: all state below uses non-blocking assignment so every register samples the
    // pre-edge values; mixing in blocking writes would make results depend on block order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            rd_ptr     <= START_PTR;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (issue) rd_ptr <= rd_ptr + 1'b1;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        rd_ptr <= START_PTR;
                        busy   <= 1'b1;
                        state  <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (issue && (rd_ptr[ADDR_WIDTH-1:0] == LAST_ADDR)) state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if ((outstanding == '0) && (fifo_count == '0)) begin
                        frame_done <= 1'b1;
                        busy       <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            outstanding  <= '0;
            fifo_count   <= '0;
            wr_idx       <= '0;
            rd_idx       <= '0;
            protocol_err <= 1'b0;
        end else begin
            case ({issue, push})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: ;
            endcase
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: ;
            endcase
            if (push) wr_idx <= wr_idx + 1'b1;
            if (pop)  rd_idx <= rd_idx + 1'b1;
            if (bus.mem_rd_data_valid && (outstanding == '0)) protocol_err <= 1'b1;
        end
    end

    // NOTE: FIFO storage is deliberately not reset; the head word is masked by out_valid,
    // so stale entries left over from an aborted frame are never observable.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_idx] <= bus.mem_rd_data;
    end

`ifdef UNDERRUN_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            underrun_cnt <= '0;
        end else if ((state == ST_IDLE) && start) begin
            underrun_cnt <= '0;
        end else if (busy && bus.out_ready && !out_valid_i && (underrun_cnt != 16'hFFFF)) begin
            underrun_cnt <= underrun_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_frame_buf_rd_ctrl.sv
// Scoreboard bench for frame_buf_rd_ctrl: stimulus pushes expected addresses/words,
// a negedge monitor pops and compares on each read issue and each accepted output word.
module tb_frame_buf_rd_ctrl;
    localparam int DW = 32;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW:0]   wr_ptr;
    logic          busy;
    logic          frame_done;
    logic          protocol_err;
`ifdef UNDERRUN_CNT_EN
    logic [15:0]   underrun_cnt;
`endif

    frame_buf_rd_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    frame_buf_rd_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .START_ADDR(2), .FIFO_DEPTH(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .wr_ptr       (wr_ptr),
        .bus          (bus),
        .busy         (busy),
        .frame_done   (frame_done),
        .protocol_err (protocol_err)
`ifdef UNDERRUN_CNT_EN
        ,
        .underrun_cnt (underrun_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory contents: addr a holds 32'hC0DE_00aa (e.g. addr 2 -> 32'hC0DE0022).
    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return 32'hC0DE_0000 | (32'(a) << 4) | 32'(a);
    endfunction

    // Memory model: fixed-latency, in-order read returns.
    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } rsp_t;

    rsp_t pend[$];
    rsp_t new_rsp;
    int   cyc    = 0;
    int   lat    = 1;
    logic inject = 1'b0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (reset) begin
            pend.delete();
            bus.mem_rd_data_valid = 1'b0;
            bus.mem_rd_data       = '0;
        end else begin
            if (!bus.mem_rd_en_l && bus.mem_rd_rdy) begin
                new_rsp.data = mem_word(bus.mem_rd_addr);
                new_rsp.due  = cyc + 1 + lat;
                pend.push_back(new_rsp);
            end
            if (pend.size() > 0 && pend[0].due == cyc + 1) begin
                bus.mem_rd_data_valid = 1'b1;
                bus.mem_rd_data       = pend[0].data;
                void'(pend.pop_front());
            end else begin
                bus.mem_rd_data_valid = inject;
                bus.mem_rd_data       = '0;
            end
        end
    end

    // Scoreboard monitor.
    logic [AW-1:0] exp_addr[$];
    logic [DW-1:0] exp_word[$];
    int iss_cnt        = 0;
    int word_cnt       = 0;
    int done_cnt       = 0;
    int model_underrun = 0;

    always @(negedge clk) begin
        if (reset === 1'b0) begin
            if (!bus.mem_rd_en_l && bus.mem_rd_rdy) begin
                iss_cnt++;
                check("issue_expected", 64'(exp_addr.size() != 0), 64'd1);
                if (exp_addr.size() != 0) check("rd_addr", 64'(bus.mem_rd_addr), 64'(exp_addr.pop_front()));
            end
            if (bus.out_valid && bus.out_ready) begin
                word_cnt++;
                check("word_expected", 64'(exp_word.size() != 0), 64'd1);
                if (exp_word.size() != 0) check("out_data", 64'(bus.out_data), 64'(exp_word.pop_front()));
            end
            if (frame_done) done_cnt++;
            if (start && !busy) model_underrun = 0;
            else if (busy && bus.out_ready && !bus.out_valid && model_underrun < 65535) model_underrun++;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_frame();
        for (int a = 2; a < 8; a++) begin
            exp_addr.push_back(AW'(a));
            exp_word.push_back(mem_word(AW'(a)));
        end
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic finish_frame(input string name, input int done_base, input int iss_base);
        int i;
        for (i = 0; i < 300 && done_cnt == done_base; i++) tick();
        check({name, "_done_seen"}, 64'(done_cnt != done_base), 64'd1);
        tick(3);
        check({name, "_done_pulses"}, 64'(done_cnt - done_base), 64'd1);
        check({name, "_busy_after"}, 64'(busy), 64'd0);
        check({name, "_issues"}, 64'(iss_cnt - iss_base), 64'd6);
        check({name, "_words_left"}, 64'(exp_word.size()), 64'd0);
        exp_addr.delete();
        exp_word.delete();
    endtask

    task automatic check_reset_vals(input string name);
        check({name, "_en_l"}, 64'(bus.mem_rd_en_l), 64'd1);
        check({name, "_addr"}, 64'(bus.mem_rd_addr), 64'd2);
        check({name, "_out_valid"}, 64'(bus.out_valid), 64'd0);
        check({name, "_out_data"}, 64'(bus.out_data), 64'd0);
        check({name, "_busy"}, 64'(busy), 64'd0);
        check({name, "_frame_done"}, 64'(frame_done), 64'd0);
        check({name, "_protocol_err"}, 64'(protocol_err), 64'd0);
    endtask

    initial begin
        int d_base;
        int i_base;
        int w_base;
        int k;

        reset          = 1'b1;
        start          = 1'b0;
        wr_ptr         = 4'b1000;
        bus.mem_rd_rdy = 1'b1;
        bus.out_ready  = 1'b1;
        #1;
        check_reset_vals("por");
        tick(2);
        reset = 1'b0;
        tick();

        // Plain frame, latency 1.
        d_base = done_cnt; i_base = iss_cnt;
        start_frame();
        finish_frame("t1", d_base, i_base);

        // Writer pointer stalls issue after addr 3.
        wr_ptr = 4'b0100;
        d_base = done_cnt; i_base = iss_cnt;
        start_frame();
        tick(10);
        check("t2_stalled_issues", 64'(iss_cnt - i_base), 64'd2);
        check("t2_en_l_held", 64'(bus.mem_rd_en_l), 64'd1);
        check("t2_addr_held", 64'(bus.mem_rd_addr), 64'd4);
        wr_ptr = 4'b1000;
        finish_frame("t2", d_base, i_base);

        // Backpressure: credit limits prefetch to two reads.
        bus.out_ready = 1'b0;
        d_base = done_cnt; i_base = iss_cnt;
        start_frame();
        tick(10);
        check("t3_credit_issues", 64'(iss_cnt - i_base), 64'd2);
        check("t3_out_valid", 64'(bus.out_valid), 64'd1);
        check("t3_head_word", 64'(bus.out_data), 64'(32'hC0DE_0022));
        check("t3_en_l_held", 64'(bus.mem_rd_en_l), 64'd1);
        bus.out_ready = 1'b1;
        finish_frame("t3", d_base, i_base);

        // Memory not ready for 3 cycles mid-frame.
        d_base = done_cnt; i_base = iss_cnt;
        start_frame();
        for (k = 0; k < 50 && iss_cnt != i_base + 3; k++) tick();
        check("t4_reached_3_issues", 64'(iss_cnt - i_base), 64'd3);
        bus.mem_rd_rdy = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("t4_addr_hold", 64'(bus.mem_rd_addr), 64'd5);
            check("t4_no_issue", 64'(iss_cnt - i_base), 64'd3);
        end
        bus.mem_rd_rdy = 1'b1;
        finish_frame("t4", d_base, i_base);

        // Latency 3.
        lat = 3;
        d_base = done_cnt; i_base = iss_cnt;
        start_frame();
        finish_frame("t6", d_base, i_base);
`ifdef UNDERRUN_CNT_EN
        check("t6_underrun_cnt", 64'(underrun_cnt), 64'(model_underrun));
`endif
        lat = 1;
        tick(2);

        // Reset after three words, then a fresh frame and a stray data-valid.
        d_base = done_cnt; i_base = iss_cnt; w_base = word_cnt;
        start_frame();
        for (k = 0; k < 50 && word_cnt != w_base + 3; k++) tick();
        check("t5_three_words", 64'(word_cnt - w_base), 64'd3);
        reset = 1'b1;
        #1;
        check_reset_vals("t5_rst");
        exp_addr.delete();
        exp_word.delete();
        tick(2);
        reset = 1'b0;
        tick();
        d_base = done_cnt; i_base = iss_cnt;
        start_frame();
        finish_frame("t5", d_base, i_base);
        check("t5_no_err_yet", 64'(protocol_err), 64'd0);
        inject = 1'b1;
        tick();
        inject = 1'b0;
        tick(2);
        check("t5_protocol_err", 64'(protocol_err), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, failed so far %0d", n_fail);
        $fatal(1);
    end

endmodule
